// File: rtl/crossbar_loader_pkg.sv
// Shared definitions for the crossbar command loader: FSM states, command byte layout and
// small constant helpers used to size the phase timer.
package crossbar_loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StGetTo,
    StSetup,
    StPulse,
    StHold
  } state_e;

  localparam int unsigned CmdWidth  = 8;
  localparam int unsigned ClearFlag = 7;

  function automatic int unsigned max2(int unsigned a, int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // A clear-column B0 is always legal; otherwise the source index must exist.
  function automatic logic from_legal(logic [CmdWidth-1:0] b0, int unsigned in_n);
    return b0[ClearFlag] || (32'(b0[6:0]) < in_n);
  endfunction

endpackage

// File: rtl/crossbar_loader_timer.sv
// Loadable down-counter with zero flag; sequences the SETUP/PULSE/HOLD phases and the
// optional B1 timeout.
module crossbar_loader_timer #(
  parameter int unsigned CntW = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic [CntW-1:0] value,
  output logic [CntW-1:0] count,
  output logic            zero
);

  assign zero = (count == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (!zero) begin
      count <= count - CntW'(1);
    end
  end

endmodule

// File: rtl/crossbar_loader.sv
// Parses two-byte route commands from the UART byte stream and drives the crossbar
// from/to/put port. Define CROSSBAR_LOADER_TIMEOUT_EN to abandon a lone B0 after TIMEOUT cycles.
module crossbar_loader
  import crossbar_loader_pkg::*;
#(
  parameter int unsigned W       = 8,
  parameter int unsigned IN      = 8,
  parameter int unsigned OUT     = 8,
  parameter int unsigned SETUP   = 2,
  parameter int unsigned PULSE   = 2,
  parameter int unsigned HOLD    = 2,
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CmdWidth-1:0] rx_data,
  input  logic                rx_valid,
  output logic                rx_ready,
  output logic [W-1:0]        from,
  output logic [W-1:0]        to,
  output logic                put,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int unsigned MaxPhase = max2(max2(SETUP, PULSE), HOLD);
`ifdef CROSSBAR_LOADER_TIMEOUT_EN
  localparam int unsigned MaxCnt = max2(MaxPhase, TIMEOUT);
`else
  localparam int unsigned MaxCnt = MaxPhase;
`endif
  localparam int unsigned CntW = $clog2(MaxCnt + 1);

  state_e              state_q;
  logic [CmdWidth-1:0] b0_q;
  logic                accept;
  logic                cmd_ok;
  logic                tmr_load;
  logic                tmr_zero;
  logic [CntW-1:0]     tmr_value;
  logic [CntW-1:0]     tmr_count;

  assign rx_ready = !reset && ((state_q == StIdle) || (state_q == StGetTo));
  assign accept   = rx_valid && rx_ready;
  assign cmd_ok   = from_legal(b0_q, IN) && (32'(rx_data) < OUT);

  // Each phase lasts N cycles, so the timer is loaded with N-1 on entry.
  always_comb begin
    tmr_load  = 1'b0;
    tmr_value = '0;
    unique case (state_q)
      StIdle: begin
`ifdef CROSSBAR_LOADER_TIMEOUT_EN
        tmr_load  = accept;
        tmr_value = CntW'(TIMEOUT - 1);
`endif
      end
      StGetTo: begin
        tmr_load  = accept && cmd_ok;
        tmr_value = CntW'(SETUP - 1);
      end
      StSetup: begin
        tmr_load  = tmr_zero;
        tmr_value = CntW'(PULSE - 1);
      end
      StPulse: begin
        tmr_load  = tmr_zero;
        tmr_value = CntW'(HOLD - 1);
      end
      default: ;
    endcase
  end

  crossbar_loader_timer #(
    .CntW (CntW)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (tmr_load),
    .value (tmr_value),
    .count (tmr_count),
    .zero  (tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      b0_q    <= '0;
      from    <= '0;
      to      <= '0;
      put     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            b0_q    <= rx_data;
            state_q <= StGetTo;
          end
        end
        StGetTo: begin
          if (accept) begin
            if (cmd_ok) begin
              from    <= b0_q[ClearFlag] ? '1 : b0_q[W-1:0];
              to      <= rx_data[W-1:0];
              busy    <= 1'b1;
              state_q <= StSetup;
            end else begin
              err     <= 1'b1;
              state_q <= StIdle;
            end
          end
`ifdef CROSSBAR_LOADER_TIMEOUT_EN
          else if (tmr_zero) begin
            err     <= 1'b1;
            state_q <= StIdle;
          end
`endif
        end
        StSetup: begin
          if (tmr_zero) begin
            put     <= 1'b1;
            state_q <= StPulse;
          end
        end
        StPulse: begin
          if (tmr_zero) begin
            put     <= 1'b0;
            done    <= (HOLD == 32'd1);
            state_q <= StHold;
          end
        end
        StHold: begin
          // done is registered, so raise it one cycle ahead of the last HOLD cycle.
          if (tmr_count == CntW'(1)) done <= 1'b1;
          if (tmr_zero) begin
            busy    <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_crossbar_loader.sv
// Randomised bench for crossbar_loader against a timeline model of command acceptance,
// put pulse, done/err pulses and reset.
module tb_crossbar_loader;

  localparam int S    = 2;
  localparam int P    = 2;
  localparam int H    = 2;
  localparam int TO   = 10;
  localparam int NIN  = 8;
  localparam int NOUT = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] from;
  logic [7:0] to;
  logic       put;
  logic       busy;
  logic       done;
  logic       err;

  crossbar_loader #(
    .W       (8),
    .IN      (NIN),
    .OUT     (NOUT),
    .SETUP   (S),
    .PULSE   (P),
    .HOLD    (H),
    .TIMEOUT (TO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .from     (from),
    .to       (to),
    .put      (put),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: cycles are numbered by the posedge that starts them.
  int         cyc    = 0;
  int         cmd_at = -1000;
  int         err_at = -1;
  int         b0_at  = 0;
  bit         have_b0 = 1'b0;
  logic [7:0] b0 = 8'h00;
  logic [7:0] exp_from = 8'h00;
  logic [7:0] exp_to = 8'h00;
  logic [7:0] q[$];
  bit         gate = 1'b1;

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic drive();
    rx_valid = (q.size() > 0) && gate;
    rx_data  = (q.size() > 0) ? q[0] : 8'h00;
  endtask

  task automatic push(logic [7:0] b);
    q.push_back(b);
    drive();
  endtask

  task automatic tick();
    bit acc;
    bit busy_e;
    bit put_e;
    bit ready_e;
    int end_at;
    @(negedge clk);
    end_at  = cmd_at + S + P + H;
    busy_e  = (cyc > cmd_at) && (cyc <= end_at);
    put_e   = busy_e && (cyc > cmd_at + S) && (cyc <= cmd_at + S + P);
    ready_e = !busy_e && !reset;
    check_eq("rx_ready", 32'(rx_ready), 32'(ready_e));
    check_eq("busy", 32'(busy), 32'(busy_e));
    check_eq("put", 32'(put), 32'(put_e));
    check_eq("done", 32'(done), 32'(cyc == end_at));
    check_eq("err", 32'(err), 32'(cyc == err_at));
    check_eq("from", 32'(from), 32'(exp_from));
    check_eq("to", 32'(to), 32'(exp_to));
    acc = rx_valid && ready_e;
    if (reset) begin
      cmd_at   = -1000;
      err_at   = -1;
      have_b0  = 1'b0;
      exp_from = 8'h00;
      exp_to   = 8'h00;
    end else if (acc) begin
      if (!have_b0) begin
        have_b0 = 1'b1;
        b0      = rx_data;
        b0_at   = cyc;
      end else begin
        have_b0 = 1'b0;
        if ((b0[7] || (int'(b0[6:0]) < NIN)) && (int'(rx_data) < NOUT)) begin
          cmd_at   = cyc;
          exp_from = b0[7] ? 8'hFF : b0;
          exp_to   = rx_data;
        end else begin
          err_at = cyc + 1;
        end
      end
    end
`ifdef CROSSBAR_LOADER_TIMEOUT_EN
    else if (have_b0 && (cyc == b0_at + TO)) begin
      have_b0 = 1'b0;
      err_at  = cyc + 1;
    end
`endif
    if (acc) void'(q.pop_front());
    @(posedge clk);
    cyc++;
    #1;
    drive();
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic logic [7:0] rand_byte();
    int r;
    r = int'($urandom_range(0, 9));
    if (r <= 5) return 8'($urandom_range(0, 7));
    if (r == 6) return 8'h80 | 8'($urandom_range(0, 127));
    if (r == 7) return 8'($urandom_range(8, 11));
    return 8'($urandom_range(0, 255));
  endfunction

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    @(posedge clk);
    #1;
    run(2);
    reset = 1'b0;

    // Basic route 3 -> 5.
    push(8'h03);
    push(8'h05);
    run(10);
    check_eq("route_from", 32'(from), 32'h03);
    check_eq("route_to", 32'(to), 32'h05);

    // Clear column 2.
    push(8'h80);
    push(8'h02);
    run(10);
    check_eq("clear_from", 32'(from), 32'hFF);

    // Illegal source index: rejected, from/to keep the clear command's values.
    push(8'h09);
    push(8'h01);
    run(5);
    check_eq("reject_to", 32'(to), 32'h02);

    // Three bytes presented back to back while the loader goes busy.
    push(8'h01);
    push(8'h02);
    push(8'h04);
    run(12);
    push(8'h06);
    run(10);
    check_eq("b2b_from", 32'(from), 32'h04);

    // Reset in the middle of the put pulse.
    push(8'h02);
    push(8'h03);
    run(2 + S + 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    run(4);

    // Lone B0 (times out when the timeout feature is built), then a normal pair.
    push(8'h01);
    run(TO + 4);
    push(8'h02);
    push(8'h03);
    run(12);

    // Random traffic with valid gaps and occasional resets.
    for (int i = 0; i < 500; i++) begin
      if (q.size() < 2 && $urandom_range(0, 3) == 0) q.push_back(rand_byte());
      gate  = ($urandom_range(0, 3) != 0);
      reset = ($urandom_range(0, 79) == 0);
      drive();
      tick();
    end
    reset = 1'b0;
    gate  = 1'b1;
    drive();
    run(30);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
